// File: rtl/ycloader.sv
// ycloader: loads COLS parallel configuration chains of Morphle yellow cells through a
// glitch-free gated strobe, holding the array in reset and reading back the old contents.
module ycloader #(
    parameter int COLS     = 4,
    parameter int ROWS     = 8,
    parameter int CBITS    = 3,
    parameter int HOLD     = 2,
    parameter int READBACK = 1
) (
    input  logic            confclk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic            wvalid,
    output logic            wready,
    input  logic [COLS-1:0] wdata,
    output logic            rvalid,
    input  logic            rready,
    output logic [COLS-1:0] rdata,
    output logic            arst_o,
    output logic            cstrobe_o,
    output logic [COLS-1:0] cbit_o,
    input  logic [COLS-1:0] cbitret
);

    localparam int CHAIN = ROWS * CBITS;
    localparam int CW    = $clog2(CHAIN + 1);
    localparam int HW    = $clog2(HOLD + 1);

    localparam logic [CW-1:0] LAST_SLICE = CW'(CHAIN - 1);
    localparam logic [HW-1:0] LAST_HOLD  = HW'(HOLD - 1);
    localparam logic          RB         = (READBACK != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [COLS-1:0] cbit_q;
    logic [COLS-1:0] rdata_q;
    logic            rvalid_q;
    logic            en_q;
    logic            en_lat_q;
    logic            stall;
    logic            accept;

    assign stall  = RB & rvalid_q & ~rready;
    assign wready = (state_q == S_SHIFT) & ~stall;
    assign accept = wvalid & wready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ARM;
            end
            S_ARM: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
            end
            S_SHIFT: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_SLICE) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == LAST_HOLD) state_d = S_DONE;
                else                     hold_d  = hold_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge confclk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            cbit_q   <= '0;
            rvalid_q <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            en_q    <= accept;
            if (accept) cbit_q <= wdata;
            if (accept)      rvalid_q <= RB;
            else if (rready) rvalid_q <= 1'b0;
        end
    end

    // en_lat_q only moves while confclk is low, so confclk & en_lat_q cannot glitch.
    // rdata is taken on the same falling edge: the previous strobe's shift has settled
    // by then and this accept's strobe has not fired yet, so back-to-back reads stay in order.
    always_ff @(negedge confclk or posedge reset) begin
        if (reset) begin
            en_lat_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            en_lat_q <= en_q;
            if (en_q && RB) rdata_q <= cbitret;
        end
    end

    assign cstrobe_o = confclk & en_lat_q;
    assign cbit_o    = cbit_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign arst_o    = reset | (state_q == S_ARM) | (state_q == S_SHIFT) | (state_q == S_HOLD);

endmodule
